// File: rtl/ibex_rvfi_trace_buffer.sv
// RVFI retirement trace capture: PC-range filter, circular record buffer, PC trigger with freeze.
// Define IBEX_TRACE_TIMESTAMP_EN to append rvfi_ext_mcycle_i[31:0] as the record MSBs.
module ibex_rvfi_trace_buffer #(
  parameter int unsigned Depth         = 16,
  parameter logic        Wrap          = 1'b0,
  parameter int unsigned PostTrigCount = 8,
`ifdef IBEX_TRACE_TIMESTAMP_EN
  localparam int unsigned RecW = 153,
`else
  localparam int unsigned RecW = 121,
`endif
  localparam int unsigned LvlW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            enable_i,
  input  logic            clear_i,
  input  logic            rvfi_valid_i,
  input  logic [63:0]     rvfi_order_i,
  input  logic [31:0]     rvfi_pc_rdata_i,
  input  logic [31:0]     rvfi_insn_i,
  input  logic            rvfi_trap_i,
  input  logic            rvfi_intr_i,
  input  logic [1:0]      rvfi_mode_i,
  input  logic [4:0]      rvfi_rd_addr_i,
  input  logic [31:0]     rvfi_rd_wdata_i,
  input  logic [63:0]     rvfi_ext_mcycle_i,
  input  logic [31:0]     filter_lo_i,
  input  logic [31:0]     filter_hi_i,
  input  logic            trigger_en_i,
  input  logic [31:0]     trigger_pc_i,
  input  logic            rd_ready_i,
  output logic            rd_valid_o,
  output logic [RecW-1:0] rd_data_o,
  output logic [LvlW-1:0] level_o,
  output logic            overflow_o,
  output logic            triggered_o,
  output logic            frozen_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StArmed  = 2'd1;
  localparam logic [1:0] StPost   = 2'd2;
  localparam logic [1:0] StFrozen = 2'd3;

  logic [RecW-1:0] mem_q [Depth];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LvlW-1:0] level_q, level_d, cnt_q, cnt_d;
  logic [1:0]      state_q, state_d;
  logic            overflow_q, overflow_d, triggered_q, triggered_d;

  logic [120:0]    rec_base;
  logic [RecW-1:0] rec;
  logic            hit, capturing, push, pop, full, empty, trig_hit, mem_we;
  logic            unused_in;

  assign rec_base = {rvfi_order_i[15:0], rvfi_mode_i, rvfi_intr_i, rvfi_trap_i,
                     rvfi_rd_addr_i, rvfi_rd_wdata_i, rvfi_insn_i, rvfi_pc_rdata_i};
`ifdef IBEX_TRACE_TIMESTAMP_EN
  assign rec       = {rvfi_ext_mcycle_i[31:0], rec_base};
  assign unused_in = ^{rvfi_order_i[63:16], rvfi_ext_mcycle_i[63:32]};
`else
  assign rec       = rec_base;
  assign unused_in = ^{rvfi_order_i[63:16], rvfi_ext_mcycle_i};
`endif

  // An inverted window (lo > hi) can never satisfy both compares, so it filters everything.
  assign hit       = rvfi_valid_i & (rvfi_pc_rdata_i >= filter_lo_i) &
                     (rvfi_pc_rdata_i <= filter_hi_i);
  assign capturing = (state_q == StArmed) | (state_q == StPost);
  assign push      = hit & capturing;
  assign empty     = (level_q == {LvlW{1'b0}});
  assign full      = (level_q == LvlW'(Depth));
  assign pop       = ~empty & rd_ready_i;
  assign trig_hit  = hit & trigger_en_i & (rvfi_pc_rdata_i == trigger_pc_i);

  // Buffer pointers, occupancy and overflow flag.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    mem_we     = 1'b0;
    if (clear_i) begin
      wptr_d     = {PtrW{1'b0}};
      rptr_d     = {PtrW{1'b0}};
      level_d    = {LvlW{1'b0}};
      overflow_d = 1'b0;
    end else if (push && (!full || pop)) begin
      mem_we = 1'b1;
      wptr_d = wptr_q + PtrW'(1);
      if (pop) begin
        rptr_d = rptr_q + PtrW'(1);
      end else begin
        level_d = level_q + LvlW'(1);
      end
    end else if (push) begin
      overflow_d = 1'b1;
      if (Wrap) begin
        mem_we = 1'b1;
        wptr_d = wptr_q + PtrW'(1);
        rptr_d = rptr_q + PtrW'(1);
      end else begin
        mem_we = 1'b0;
      end
    end else if (pop) begin
      rptr_d  = rptr_q + PtrW'(1);
      level_d = level_q - LvlW'(1);
    end else begin
      level_d = level_q;
    end
  end

  // Capture FSM with post-trigger countdown.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    triggered_d = triggered_q;
    if (clear_i) begin
      state_d     = StIdle;
      cnt_d       = {LvlW{1'b0}};
      triggered_d = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (enable_i) state_d = StArmed;
          else          state_d = StIdle;
        end
        StArmed: begin
          if (!enable_i) begin
            state_d = StIdle;
          end else if (trig_hit) begin
            triggered_d = 1'b1;
            cnt_d       = LvlW'(PostTrigCount);
            state_d     = (PostTrigCount == 32'd0) ? StFrozen : StPost;
          end else begin
            state_d = StArmed;
          end
        end
        StPost: begin
          if (!enable_i) begin
            state_d = StIdle;
          end else if (push) begin
            cnt_d   = cnt_q - LvlW'(1);
            state_d = (cnt_q == LvlW'(1)) ? StFrozen : StPost;
          end else begin
            state_d = StPost;
          end
        end
        StFrozen: state_d = StFrozen;
        default:  state_d = StIdle;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q      <= {PtrW{1'b0}};
      rptr_q      <= {PtrW{1'b0}};
      level_q     <= {LvlW{1'b0}};
      cnt_q       <= {LvlW{1'b0}};
      state_q     <= StIdle;
      overflow_q  <= 1'b0;
      triggered_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      overflow_q  <= overflow_d;
      triggered_q <= triggered_d;
    end
  end

  // Record storage; contents need no reset because reads are gated by occupancy.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[wptr_q] <= rec;
    end
  end

  assign rd_valid_o  = ~empty;
  assign rd_data_o   = empty ? {RecW{1'b0}} : mem_q[rptr_q];
  assign level_o     = level_q;
  assign overflow_o  = overflow_q;
  assign triggered_o = triggered_q;
  assign frozen_o    = (state_q == StFrozen);

endmodule

// File: tb/tb_ibex_rvfi_trace_buffer.sv
// Self-checking bench for ibex_rvfi_trace_buffer: three parameterisations share one stimulus
// stream and are compared every cycle against a queue-based behavioural model.
module tb_ibex_rvfi_trace_buffer;
`ifdef IBEX_TRACE_TIMESTAMP_EN
  localparam int RW = 153;
`else
  localparam int RW = 121;
`endif
  localparam int NI = 3;
  localparam int DEPTH = 16;
  localparam int M_IDLE = 0, M_ARMED = 1, M_POST = 2, M_FROZEN = 3;

  logic clk = 1'b0, rst_n, enable, clear, valid, trap, intr, trig_en, ready;
  logic [63:0] order, mcycle;
  logic [31:0] pc, insn, rd_wdata, flo, fhi, trig_pc;
  logic [1:0]  mode;
  logic [4:0]  rd_addr;

  logic          rd_valid [NI];
  logic [RW-1:0] rd_data  [NI];
  logic [4:0]    level    [NI];
  logic          ovf [NI], trg [NI], frz [NI];

  always #5 clk = ~clk;

  // Instance 0: drop on full, 3 post-trigger records; 1: overwrite, 8; 2: drop, 0.
  for (genvar g = 0; g < NI; g++) begin : g_dut
    ibex_rvfi_trace_buffer #(
      .Depth(DEPTH), .Wrap(g == 1), .PostTrigCount(g == 0 ? 3 : (g == 1 ? 8 : 0))
    ) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .clear_i(clear),
      .rvfi_valid_i(valid), .rvfi_order_i(order), .rvfi_pc_rdata_i(pc), .rvfi_insn_i(insn),
      .rvfi_trap_i(trap), .rvfi_intr_i(intr), .rvfi_mode_i(mode), .rvfi_rd_addr_i(rd_addr),
      .rvfi_rd_wdata_i(rd_wdata), .rvfi_ext_mcycle_i(mcycle),
      .filter_lo_i(flo), .filter_hi_i(fhi), .trigger_en_i(trig_en), .trigger_pc_i(trig_pc),
      .rd_ready_i(ready), .rd_valid_o(rd_valid[g]), .rd_data_o(rd_data[g]),
      .level_o(level[g]), .overflow_o(ovf[g]), .triggered_o(trg[g]), .frozen_o(frz[g])
    );
  end

  // Behavioural model state
  logic [RW-1:0] mq [NI][$];
  bit m_ovf [NI], m_trg [NI];
  int m_st [NI], m_cnt [NI];
  int n_assert = 0, n_fail = 0;

  function automatic bit wrap_of(int k); return k == 1; endfunction
  function automatic int ptc_of(int k); return (k == 0) ? 3 : ((k == 1) ? 8 : 0); endfunction

  function automatic logic [RW-1:0] mk_rec();
`ifdef IBEX_TRACE_TIMESTAMP_EN
    return {mcycle[31:0], order[15:0], mode, intr, trap, rd_addr, rd_wdata, insn, pc};
`else
    return {order[15:0], mode, intr, trap, rd_addr, rd_wdata, insn, pc};
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      mq[k].delete();
      m_ovf[k] = 0; m_trg[k] = 0; m_st[k] = M_IDLE; m_cnt[k] = 0;
    end
  endtask

  task automatic model_step();
    logic [RW-1:0] r;
    bit hit, was_full, pop, push;
    r   = mk_rec();
    hit = valid && (pc >= flo) && (pc <= fhi);
    for (int k = 0; k < NI; k++) begin
      if (clear) begin
        mq[k].delete(); m_ovf[k] = 0; m_trg[k] = 0; m_st[k] = M_IDLE;
      end else begin
        was_full = (mq[k].size() == DEPTH);
        pop      = ready && (mq[k].size() > 0);
        push     = hit && (m_st[k] == M_ARMED || m_st[k] == M_POST);
        if (pop) void'(mq[k].pop_front());
        if (push) begin
          if (!was_full || pop) mq[k].push_back(r);
          else begin
            m_ovf[k] = 1;
            if (wrap_of(k)) begin void'(mq[k].pop_front()); mq[k].push_back(r); end
          end
        end
        case (m_st[k])
          M_IDLE:  if (enable) m_st[k] = M_ARMED;
          M_ARMED: if (!enable) m_st[k] = M_IDLE;
                   else if (hit && trig_en && pc == trig_pc) begin
                     m_trg[k] = 1; m_cnt[k] = ptc_of(k);
                     m_st[k] = (ptc_of(k) == 0) ? M_FROZEN : M_POST;
                   end
          M_POST:  if (!enable) m_st[k] = M_IDLE;
                   else if (push) begin
                     m_cnt[k]--;
                     if (m_cnt[k] == 0) m_st[k] = M_FROZEN;
                   end
          default: ;
        endcase
      end
    end
  endtask

  task automatic chk(string tag, logic [RW-1:0] obs, logic [RW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string w);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("%s.u%0d.rd_valid", w, k), RW'(rd_valid[k]), RW'(mq[k].size() > 0));
      chk($sformatf("%s.u%0d.level", w, k), RW'(level[k]), RW'(mq[k].size()));
      chk($sformatf("%s.u%0d.rd_data", w, k), rd_data[k],
          (mq[k].size() > 0) ? mq[k][0] : {RW{1'b0}});
      chk($sformatf("%s.u%0d.overflow", w, k), RW'(ovf[k]), RW'(m_ovf[k]));
      chk($sformatf("%s.u%0d.triggered", w, k), RW'(trg[k]), RW'(m_trg[k]));
      chk($sformatf("%s.u%0d.frozen", w, k), RW'(frz[k]), RW'(m_st[k] == M_FROZEN));
    end
  endtask

  task automatic tick(string w);
    @(posedge clk);
    model_step();
    #1;
    check_all(w);
  endtask

  task automatic set_ret(bit v, logic [31:0] p);
    valid = v; pc = p; insn = $urandom; rd_wdata = $urandom;
    rd_addr = 5'($urandom); mode = 2'($urandom); trap = 1'($urandom); intr = 1'($urandom);
    order = {$urandom, $urandom}; mcycle = {$urandom, $urandom};
  endtask

  task automatic do_clear();
    clear = 1'b1; set_ret(0, 32'h0); tick("clear");
    clear = 1'b0; tick("rearm");
  endtask

  initial begin
    logic [31:0] fpcs [4];
    logic [RW-1:0] hd;
    rst_n = 1'b0; enable = 1'b0; clear = 1'b0; ready = 1'b0;
    flo = 32'h0; fhi = 32'hFFFF_FFFF; trig_en = 1'b0; trig_pc = 32'h0;
    set_ret(0, 32'h0);
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk); rst_n = 1'b1;

    // Fill past capacity: drop (u0,u2) versus overwrite (u1)
    enable = 1'b1; tick("arm");
    for (int i = 0; i < 20; i++) begin set_ret(1, 32'h100 + 4 * i); tick("fill"); end
    set_ret(0, 32'h0); tick("fill_idle");
    chk("fill.u0.level", RW'(level[0]), RW'(16));
    chk("fill.u0.overflow", RW'(ovf[0]), RW'(1));
    chk("fill.u1.level", RW'(level[1]), RW'(16));
    chk("fill.u1.overflow", RW'(ovf[1]), RW'(1));
    ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain.u0.pc", RW'(rd_data[0][31:0]), RW'(32'h100 + 4 * i));
      chk("drain.u1.pc", RW'(rd_data[1][31:0]), RW'(32'h110 + 4 * i));
      tick("drain");
    end
    ready = 1'b0;

    // PC range filter, then an inverted window
    do_clear();
    flo = 32'h1000; fhi = 32'h1FFF;
    fpcs = '{32'h0FFC, 32'h1000, 32'h1FFC, 32'h2000};
    for (int i = 0; i < 4; i++) begin set_ret(1, fpcs[i]); tick("filter"); end
    chk("filter.level", RW'(level[0]), RW'(2));
    chk("filter.head", RW'(rd_data[0][31:0]), RW'(32'h1000));
    flo = 32'h2000; fhi = 32'h1000; set_ret(1, 32'h1800); tick("inverted");
    chk("inverted.level", RW'(level[0]), RW'(2));

    // Trigger with post count 3 (u0) and 0 (u2)
    do_clear();
    flo = 32'h0; fhi = 32'hFFFF_FFFF; trig_en = 1'b1; trig_pc = 32'h2000;
    set_ret(1, 32'h1F00); tick("pretrig");
    set_ret(1, 32'h1F04); tick("pretrig");
    for (int i = 0; i < 8; i++) begin set_ret(1, 32'h2000 + 4 * i); tick("trig"); end
    chk("trig.u0.level", RW'(level[0]), RW'(6));
    chk("trig.u0.frozen", RW'(frz[0]), RW'(1));
    chk("trig.u2.level", RW'(level[2]), RW'(3));
    chk("trig.u2.frozen", RW'(frz[2]), RW'(1));
    trig_en = 1'b0;

    // Full buffer with simultaneous push and pop, then clear alongside a push
    do_clear();
    for (int i = 0; i < 16; i++) begin set_ret(1, 32'h300 + 4 * i); tick("full"); end
    ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_ret(1, 32'h400 + 4 * i); tick("pushpop");
      chk("pushpop.level", RW'(level[0]), RW'(16));
      chk("pushpop.overflow", RW'(ovf[0]), RW'(0));
    end
    ready = 1'b0; clear = 1'b1; set_ret(1, 32'h500); tick("clear_push");
    chk("clear_push.level", RW'(level[0]), RW'(0));
    clear = 1'b0; set_ret(0, 32'h0); tick("rearm");

    // Head held while consumer stalls
    for (int i = 0; i < 3; i++) begin set_ret(1, 32'h600 + 4 * i); tick("hold_fill"); end
    set_ret(0, 32'h0);
    hd = mq[0][0];
    for (int i = 0; i < 5; i++) begin
      tick("hold");
      chk("hold.rd_data", rd_data[0], hd);
    end

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      if (i % 64 == 0) begin
        flo = 32'h1000 + 4 * $urandom_range(0, 40);
        fhi = 32'h1000 + 4 * $urandom_range(20, 63);
        trig_en = 1'($urandom); trig_pc = 32'h1000 + 4 * $urandom_range(0, 63);
      end
      enable = ($urandom_range(0, 15) != 0);
      clear  = ($urandom_range(0, 31) == 0);
      ready  = 1'($urandom);
      set_ret(1'($urandom), 32'h1000 + 4 * $urandom_range(0, 63));
      tick("rand");
    end

    // Reset in the middle of capture
    clear = 1'b0; enable = 1'b1; ready = 1'b0; trig_en = 1'b0;
    flo = 32'h0; fhi = 32'hFFFF_FFFF;
    do_clear();
    for (int i = 0; i < 4; i++) begin set_ret(1, 32'h700 + 4 * i); tick("precap"); end
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("midrst");
    chk("midrst.u0.level", RW'(level[0]), RW'(0));
    chk("midrst.u0.rd_valid", RW'(rd_valid[0]), RW'(0));
    @(negedge clk); rst_n = 1'b1;
    set_ret(0, 32'h0); enable = 1'b0; tick("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
